// File: rtl/pattern_cclut_encoder_pkg.sv
// Shared widths and constants for the CCLUT pattern encoder, plus the
// edge-clamp helper that turns a signed raw position into an eighth-strip index.
package pattern_params;

    localparam int MXHSB           = 8;
    localparam int NHS             = 224;
    localparam int MXOFFSB         = 4;
    localparam int MXBNDB          = 5;
    localparam int MXQLTB          = 9;
    localparam int MXPIDB          = 4;
    localparam int MXESB           = 10;
    localparam int CCLUT_ZERO_OFFS = 7;

    // Two extra bits: one for the sign, one for key_hs values beyond NHS.
    localparam int RAW_W  = MXESB + 2;
    localparam int ES_MAX = 4 * NHS - 1;

    typedef struct packed {
        logic [MXPIDB-1:0] pid;
        logic [MXBNDB-1:0] bend;
        logic [MXQLTB-1:0] quality;
    } cand_meta_t;

    typedef struct packed {
        logic [MXESB-1:0] es;
        logic             clamped;
    } es_clamp_t;

    function automatic es_clamp_t clamp_es(input logic [RAW_W-1:0] raw);
        es_clamp_t r;
        r.clamped = 1'b1;
        if (raw[RAW_W-1]) begin
            r.es = '0;
        end else if (raw > RAW_W'(ES_MAX)) begin
            r.es = MXESB'(ES_MAX);
        end else begin
            r.es      = raw[MXESB-1:0];
            r.clamped = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pattern_cclut_encoder_if.sv
// Candidate bus between the CCLUT lookup stage and the encoder, and the
// encoded position bus towards the CLCT builder.
interface pattern_cclut_encoder_if;
    import pattern_params::*;

    logic              vld0, vld1;
    logic [MXHSB-1:0]  key_hs0, key_hs1;
    logic [MXPIDB-1:0] pid0, pid1;
    logic [MXOFFSB-1:0] offs0, offs1;
    logic [MXBNDB-1:0] bend0, bend1;
    logic [MXQLTB-1:0] quality0, quality1;

    logic              out_vld0, out_vld1;
    logic [MXHSB-1:0]  out_hs0, out_hs1;
    logic              out_qs0, out_qs1;
    logic              out_es0, out_es1;
    logic [MXPIDB-1:0] out_pid0, out_pid1;
    logic [MXBNDB-1:0] out_bend0, out_bend1;
    logic [MXQLTB-1:0] out_quality0, out_quality1;

    modport master (
        output vld0, vld1, key_hs0, key_hs1, pid0, pid1, offs0, offs1,
               bend0, bend1, quality0, quality1,
        input  out_vld0, out_vld1, out_hs0, out_hs1, out_qs0, out_qs1,
               out_es0, out_es1, out_pid0, out_pid1, out_bend0, out_bend1,
               out_quality0, out_quality1
    );

    modport slave (
        input  vld0, vld1, key_hs0, key_hs1, pid0, pid1, offs0, offs1,
               bend0, bend1, quality0, quality1,
        output out_vld0, out_vld1, out_hs0, out_hs1, out_qs0, out_qs1,
               out_es0, out_es1, out_pid0, out_pid1, out_bend0, out_bend1,
               out_quality0, out_quality1
    );

endinterface

// File: rtl/pattern_cclut_encoder_es_pos_calc.sv
// Single-candidate position calculator: stage 1 registers the signed raw
// eighth-strip position, stage 2 registers the edge-clamped position.
module es_pos_calc
    import pattern_params::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               vld,
    input  logic [MXHSB-1:0]   key_hs,
    input  logic [MXOFFSB-1:0] offs,
    output logic               s1_vld,
    output logic [MXESB-1:0]   s1_es,
    output logic               s1_clamp,
    output logic [MXESB-1:0]   es_pos
);

    logic [RAW_W-1:0] raw_next;
    logic [RAW_W-1:0] raw_q;
    es_clamp_t        s1_clamped;

    // Offset code 7 is the zero shift; wraps below zero land on the sign bit.
    assign raw_next = RAW_W'({key_hs, 2'b00}) + RAW_W'(offs) - RAW_W'(CCLUT_ZERO_OFFS);

    // NOTE: non-blocking assignments keep both pipeline stages advancing on the
    // same edge; every register here is reset so in-flight candidates are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            raw_q  <= '0;
            s1_vld <= 1'b0;
            es_pos <= '0;
        end else begin
            raw_q  <= raw_next;
            s1_vld <= vld;
            es_pos <= s1_clamped.es;
        end
    end

    assign s1_clamped = clamp_es(raw_q);
    assign s1_es      = s1_clamped.es;
    assign s1_clamp   = s1_vld & s1_clamped.clamped;

endmodule

// File: rtl/pattern_cclut_encoder.sv
// Two-candidate CCLUT encoder: eighth-strip key positions with edge clamping,
// duplicate suppression (candidate 0 wins) and saturating event counters.
module pattern_cclut_encoder
    import pattern_params::*;
#(
    parameter int MXCNTB = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cnt_clear,
    pattern_cclut_encoder_if.slave bus,
    output logic [MXCNTB-1:0]     clamp_cnt,
    output logic [MXCNTB-1:0]     dup_cnt
);

    logic             s1_vld0, s1_vld1;
    logic             s1_clamp0, s1_clamp1;
    logic [MXESB-1:0] s1_es0, s1_es1;
    logic [MXESB-1:0] es_pos0, es_pos1;
    logic             out_vld0_q, out_vld1_q;
    logic             dup_evt, clamp_evt;

    cand_meta_t meta_in0, meta_in1;
    cand_meta_t meta_s1_0, meta_s1_1;
    cand_meta_t meta_s2_0, meta_s2_1;

    es_pos_calc u_pos0 (
        .clock    (clock),
        .reset_n  (reset_n),
        .vld      (bus.vld0),
        .key_hs   (bus.key_hs0),
        .offs     (bus.offs0),
        .s1_vld   (s1_vld0),
        .s1_es    (s1_es0),
        .s1_clamp (s1_clamp0),
        .es_pos   (es_pos0)
    );

    es_pos_calc u_pos1 (
        .clock    (clock),
        .reset_n  (reset_n),
        .vld      (bus.vld1),
        .key_hs   (bus.key_hs1),
        .offs     (bus.offs1),
        .s1_vld   (s1_vld1),
        .s1_es    (s1_es1),
        .s1_clamp (s1_clamp1),
        .es_pos   (es_pos1)
    );

    assign meta_in0 = '{pid: bus.pid0, bend: bus.bend0, quality: bus.quality0};
    assign meta_in1 = '{pid: bus.pid1, bend: bus.bend1, quality: bus.quality1};

    // Duplicates are judged on clamped positions, so two candidates pinned to
    // the same chamber edge also count as one.
    assign dup_evt   = s1_vld0 & s1_vld1 & (s1_es0 == s1_es1);
    assign clamp_evt = s1_clamp0 | s1_clamp1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_s1_0  <= '0;
            meta_s1_1  <= '0;
            meta_s2_0  <= '0;
            meta_s2_1  <= '0;
            out_vld0_q <= 1'b0;
            out_vld1_q <= 1'b0;
        end else begin
            meta_s1_0  <= meta_in0;
            meta_s1_1  <= meta_in1;
            meta_s2_0  <= meta_s1_0;
            meta_s2_1  <= meta_s1_1;
            out_vld0_q <= s1_vld0;
            out_vld1_q <= s1_vld1 & ~dup_evt;
        end
    end

    // Clear beats increment; at all-ones the counter holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clamp_cnt <= '0;
            dup_cnt   <= '0;
        end else if (cnt_clear) begin
            clamp_cnt <= '0;
            dup_cnt   <= '0;
        end else begin
            if (clamp_evt && (clamp_cnt != '1)) clamp_cnt <= clamp_cnt + MXCNTB'(1);
            if (dup_evt && (dup_cnt != '1))     dup_cnt   <= dup_cnt + MXCNTB'(1);
        end
    end

    assign bus.out_vld0     = out_vld0_q;
    assign bus.out_vld1     = out_vld1_q;
    assign bus.out_hs0      = es_pos0[MXESB-1:2];
    assign bus.out_hs1      = es_pos1[MXESB-1:2];
    assign bus.out_qs0      = es_pos0[1];
    assign bus.out_qs1      = es_pos1[1];
    assign bus.out_es0      = es_pos0[0];
    assign bus.out_es1      = es_pos1[0];
    assign bus.out_pid0     = meta_s2_0.pid;
    assign bus.out_pid1     = meta_s2_1.pid;
    assign bus.out_bend0    = meta_s2_0.bend;
    assign bus.out_bend1    = meta_s2_1.bend;
    assign bus.out_quality0 = meta_s2_0.quality;
    assign bus.out_quality1 = meta_s2_1.quality;

endmodule

// File: tb/tb_pattern_cclut_encoder.sv
// Scoreboard bench for pattern_cclut_encoder: the driver pushes model results,
// a negedge monitor pops and compares them two clocks after issue.
module tb_pattern_cclut_encoder;
    import pattern_params::*;

    localparam int CNTW    = 6;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            cnt_clear = 1'b0;
    logic [CNTW-1:0] clamp_cnt, dup_cnt;

    pattern_cclut_encoder_if bus ();

    pattern_cclut_encoder #(.MXCNTB(CNTW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cnt_clear (cnt_clear),
        .bus       (bus.slave),
        .clamp_cnt (clamp_cnt),
        .dup_cnt   (dup_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit v[2];
        int hs[2];
        int offs[2];
        int pid[2];
        int bend[2];
        int q[2];
    } bx_t;

    typedef struct {
        int due;
        bit vld[2];
        int es[2];
        int pid[2];
        int bend[2];
        int q[2];
        bit clamp;
        bit dup;
        int clamp_cnt;
        int dup_cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t pending;
    bit   pending_v = 1'b0;
    int   cyc = 0;
    int   m_clamp = 0, m_dup = 0;
    int   n_checks = 0, n_errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference position: 4 quarter... eighth-strips per halfstrip, offset code 7 = no shift.
    function automatic int ref_raw(int hs, int offs);
        return 4 * hs + offs - CCLUT_ZERO_OFFS;
    endfunction

    function automatic int ref_es(int hs, int offs);
        int r = ref_raw(hs, offs);
        if (r < 0) return 0;
        if (r > 4 * NHS - 1) return 4 * NHS - 1;
        return r;
    endfunction

    function automatic bit ref_clamped(int hs, int offs);
        int r = ref_raw(hs, offs);
        return (r < 0) || (r > 4 * NHS - 1);
    endfunction

    function automatic bx_t mk(bit v0, int h0, int o0, bit v1, int h1, int o1);
        bx_t b;
        b.v[0] = v0;  b.hs[0] = h0;  b.offs[0] = o0;
        b.v[1] = v1;  b.hs[1] = h1;  b.offs[1] = o1;
        for (int i = 0; i < 2; i++) begin
            b.pid[i]  = $urandom_range(0, 15);
            b.bend[i] = $urandom_range(0, 31);
            b.q[i]    = $urandom_range(0, 511);
        end
        return b;
    endfunction

    task automatic apply(input bx_t b, input bit clr);
        bus.vld0     = b.v[0];
        bus.vld1     = b.v[1];
        bus.key_hs0  = MXHSB'(b.hs[0]);
        bus.key_hs1  = MXHSB'(b.hs[1]);
        bus.offs0    = MXOFFSB'(b.offs[0]);
        bus.offs1    = MXOFFSB'(b.offs[1]);
        bus.pid0     = MXPIDB'(b.pid[0]);
        bus.pid1     = MXPIDB'(b.pid[1]);
        bus.bend0    = MXBNDB'(b.bend[0]);
        bus.bend1    = MXBNDB'(b.bend[1]);
        bus.quality0 = MXQLTB'(b.q[0]);
        bus.quality1 = MXQLTB'(b.q[1]);
        cnt_clear    = clr;
    endtask

    // clr issued with bx k acts on the counter update caused by bx k-1,
    // so the previous expectation is completed and queued here.
    task automatic drive(input bx_t b, input bit clr);
        @(posedge clock);
        #1;
        apply(b, clr);
        if (clr) begin
            m_clamp = 0;
            m_dup   = 0;
        end else if (pending_v) begin
            if (pending.clamp && m_clamp < CNT_MAX) m_clamp++;
            if (pending.dup && m_dup < CNT_MAX)     m_dup++;
        end
        if (pending_v) begin
            pending.clamp_cnt = m_clamp;
            pending.dup_cnt   = m_dup;
            sb_q.push_back(pending);
        end
        pending.due = cyc + 2;
        for (int i = 0; i < 2; i++) begin
            pending.es[i]   = ref_es(b.hs[i], b.offs[i]);
            pending.pid[i]  = b.pid[i];
            pending.bend[i] = b.bend[i];
            pending.q[i]    = b.q[i];
        end
        pending.clamp  = (b.v[0] && ref_clamped(b.hs[0], b.offs[0])) ||
                         (b.v[1] && ref_clamped(b.hs[1], b.offs[1]));
        pending.dup    = b.v[0] && b.v[1] && (pending.es[0] == pending.es[1]);
        pending.vld[0] = b.v[0];
        pending.vld[1] = b.v[1] && !pending.dup;
        pending_v      = 1'b1;
    endtask

    // Monitor: every output slot is compared, including qualified-invalid fields.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                check("sb_timing", cyc, e.due);
                check("out_vld0", bus.out_vld0, e.vld[0]);
                check("out_vld1", bus.out_vld1, e.vld[1]);
                check("out_hs0", bus.out_hs0, e.es[0] / 4);
                check("out_qs0", bus.out_qs0, (e.es[0] / 2) % 2);
                check("out_es0", bus.out_es0, e.es[0] % 2);
                check("out_hs1", bus.out_hs1, e.es[1] / 4);
                check("out_qs1", bus.out_qs1, (e.es[1] / 2) % 2);
                check("out_es1", bus.out_es1, e.es[1] % 2);
                check("out_pid0", bus.out_pid0, e.pid[0]);
                check("out_pid1", bus.out_pid1, e.pid[1]);
                check("out_bend0", bus.out_bend0, e.bend[0]);
                check("out_bend1", bus.out_bend1, e.bend[1]);
                check("out_quality0", bus.out_quality0, e.q[0]);
                check("out_quality1", bus.out_quality1, e.q[1]);
                check("clamp_cnt", clamp_cnt, e.clamp_cnt);
                check("dup_cnt", dup_cnt, e.dup_cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bx_t idle;
        bx_t b;
        int  h, o;
        idle = mk(0, 0, 0, 0, 0, 0);
        apply(idle, 0);

        repeat (3) @(posedge clock);
        #1;
        check("rst_out_vld0", bus.out_vld0, 0);
        check("rst_out_vld1", bus.out_vld1, 0);
        check("rst_out_hs0", bus.out_hs0, 0);
        check("rst_clamp_cnt", clamp_cnt, 0);
        check("rst_dup_cnt", dup_cnt, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed cases from the plan; positions are checked through the model.
        drive(mk(1, 100, 7, 0, 0, 7), 0);
        drive(mk(1, 100, 0, 0, 0, 7), 0);
        drive(mk(1, 100, 15, 0, 0, 7), 0);
        drive(mk(1, 0, 3, 0, 0, 7), 0);
        drive(mk(1, 223, 15, 0, 0, 7), 0);
        drive(mk(1, 50, 11, 1, 51, 7), 0);
        drive(mk(1, 50, 11, 1, 60, 7), 0);
        drive(mk(0, 10, 7, 1, 10, 7), 0);
        drive(mk(1, 255, 15, 1, 250, 0), 0);
        drive(mk(0, 0, 0, 1, 0, 0), 0);

        repeat (300) begin
            h = $urandom_range(0, 255);
            o = $urandom_range(0, 15);
            b = mk($urandom_range(0, 1), h, o, $urandom_range(0, 1),
                   $urandom_range(0, 255), $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                b.hs[1]   = h;
                b.offs[1] = o;
            end
            drive(b, $urandom_range(0, 15) == 0);
        end

        // Saturation: both candidates clamp and collide every bx.
        drive(mk(0, 0, 0, 0, 0, 0), 1);
        repeat (CNT_MAX + 6) drive(mk(1, 0, 0, 1, 0, 1), 0);
        drive(mk(1, 0, 0, 0, 0, 0), 0);
        drive(mk(1, 240, 9, 0, 0, 0), 1);
        repeat (3) drive(mk(1, 0, 2, 1, 0, 5), 0);

        repeat (4) drive(idle, 0);
        for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(negedge clock);
        check("sb_drain", sb_q.size(), 0);
        pending_v = 1'b0;

        // Reset one clock after a valid input: nothing may emerge.
        @(posedge clock);
        #1;
        apply(mk(1, 30, 7, 1, 40, 7), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        apply(idle, 0);
        #1;
        check("mid_rst_out_vld0", bus.out_vld0, 0);
        check("mid_rst_out_vld1", bus.out_vld1, 0);
        check("mid_rst_out_hs0", bus.out_hs0, 0);
        check("mid_rst_out_pid0", bus.out_pid0, 0);
        check("mid_rst_out_quality1", bus.out_quality1, 0);
        check("mid_rst_clamp_cnt", clamp_cnt, 0);
        check("mid_rst_dup_cnt", dup_cnt, 0);
        @(negedge clock);
        check("held_rst_out_vld0", bus.out_vld0, 0);
        reset_n = 1'b1;
        m_clamp = 0;
        m_dup   = 0;
        repeat (2) begin
            @(negedge clock);
            check("post_rst_out_vld0", bus.out_vld0, 0);
            check("post_rst_out_vld1", bus.out_vld1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
